// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard controller.
package pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CD_W     = 8;

    // ID/EXE control fields; a bubble loads all of them as zero.
    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] exe;
    } idexe_ctrl_t;

    localparam idexe_ctrl_t IDEXE_NOP = '0;

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter with zero flag; tracks remaining mult/div busy cycles.
// Load has priority over decrement; decrement stops at zero.
module md_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes and mult/div EXE freezes.
// Control outputs are combinational from state and inputs; md_done and stall_cycles are registered.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src2,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_dest,
    input  logic             exe_md_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             exe_hold,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // Start cycle is the first stall, so the counter covers the remaining MD_LATENCY-1.
    localparam logic [CD_W-1:0] MD_LOAD = CD_W'(MD_LATENCY - 1);

    state_t          state, state_nxt;
    logic [CD_W-1:0] cd_count;
    logic            cd_zero;
    logic            cd_load;
    logic            cd_dec;
    logic            load_use;
    logic            md_last;

    assign load_use = exe_mem_read && (exe_dest != REG_ZERO) &&
                      ((exe_dest == id_src1) || (id_uses_src2 && (exe_dest == id_src2)));

    // A zero count while busy can only follow a bad load; leaving avoids a lockup.
    assign md_last = (state == MD_BUSY) && ((cd_count == CD_W'(1)) || cd_zero);

    md_timer #(.W(CD_W)) u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load),
        .load_val (MD_LOAD),
        .dec      (cd_dec),
        .count    (cd_count),
        .zero     (cd_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        exe_hold     = 1'b0;
        md_busy      = 1'b0;
        cd_load      = 1'b0;
        cd_dec       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                end else if (exe_md_start) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    cd_load    = 1'b1;
                    state_nxt  = MD_BUSY;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idexe_bubble = 1'b1;
                end
            end
            MD_BUSY: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exe_hold   = 1'b1;
                md_busy    = 1'b1;
                cd_dec     = 1'b1;
                if (md_last) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_done      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            md_done <= md_last;
            if (!pc_write) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
